// File: rtl/edge_frame_sequencer_if.sv
// rtl/edge_frame_sequencer_if.sv - frame buffer read port and edge stage pixel bus
//
// Groups the sequencer's frame buffer read port and its edge stage outputs.
//   MemRd     frame buffer read strobe (sequencer -> buffer)
//   MemAddr   16-bit read address (sequencer -> buffer)
//   MemData   8-bit read data, valid the cycle after MemRd (buffer -> sequencer)
//   PixelOut  8-bit pixel to the edge stage
//   FrameOut  high with the first pixel of the frame
//   LineOut   high with the first pixel of every line
//   Width     latched frame width for the edge stage
// master: the sequencer side; slave: the frame buffer / edge stage side.
interface edge_frame_sequencer_if;
  logic        MemRd;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic [7:0]  PixelOut;
  logic        FrameOut;
  logic        LineOut;
  logic [7:0]  Width;

  modport master (
    output MemRd, MemAddr, PixelOut, FrameOut, LineOut, Width,
    input  MemData
  );

  modport slave (
    input  MemRd, MemAddr, PixelOut, FrameOut, LineOut, Width,
    output MemData
  );
endinterface

// File: rtl/edge_frame_sequencer.sv
// rtl/edge_frame_sequencer.sv - raster-scan frame sequencer feeding the edge stage
//
// On Start (in IDLE) latches the frame geometry, reads the frame buffer in
// raster order, forwards each pixel with frame/line start tags two cycles
// after its read, flushes the edge stage for DRAIN_CYCLES cycles and pulses
// Done. Abort returns to IDLE from any state and clears the read pipeline.
//   Clk        clock, rising edge
//   nReset     asynchronous active-low reset
//   Start      level-sampled start request, acted on only in IDLE
//   Abort      synchronous abort, acted on in any state
//   CfgWidth   frame width in pixels
//   CfgHeight  frame height in lines
//   Busy       high while fetching or draining
//   Done       one-cycle completion pulse
//   bus        frame buffer read port and edge stage outputs (master side)
module edge_frame_sequencer #(
  parameter int DRAIN_CYCLES = 104
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic                          Start,
  input  logic                          Abort,
  input  logic [7:0]                    CfgWidth,
  input  logic [7:0]                    CfgHeight,
  output logic                          Busy,
  output logic                          Done,
  edge_frame_sequencer_if.master        bus
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]     width_q;
  logic [7:0]     height_q;
  logic [15:0]    addr_q;
  logic [7:0]     col_q;
  logic [7:0]     row_q;
  logic [DCW-1:0] drain_q;

  // read pipeline: stage 1 tags ride alongside the read, stage 2 meets the data
  logic           v1_q;
  logic           line1_q;
  logic           frame1_q;
  logic [7:0]     pix_q;
  logic           line_q;
  logic           frame_q;

  logic mem_rd;
  logic start_accept;
  logic last_fetch;
  logic drain_last;

  assign start_accept = (state == S_IDLE) && Start && !Abort;
  assign last_fetch   = (col_q == width_q - 8'd1) && (row_q == height_q - 8'd1);
  assign drain_last   = (drain_q == DCW'(DRAIN_CYCLES - 1));

  // state register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; Abort overrides everything, including a same-cycle Start
  always_comb begin
    state_nxt = state;
    if (Abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state_nxt = (CfgWidth == 8'd0 || CfgHeight == 8'd0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: if (last_fetch) state_nxt = S_DRAIN;
        S_DRAIN: if (drain_last) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    mem_rd = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        Busy   = 1'b1;
      end
      S_DRAIN: Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  // geometry latch; Width holds its value across Abort and into IDLE
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      width_q  <= 8'd0;
      height_q <= 8'd0;
    end else if (start_accept) begin
      width_q  <= CfgWidth;
      height_q <= CfgHeight;
    end
  end

  // scan counters sit at zero outside FETCH so every frame starts at the origin
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      addr_q <= 16'd0;
      col_q  <= 8'd0;
      row_q  <= 8'd0;
    end else if (state == S_FETCH && !Abort && !last_fetch) begin
      addr_q <= addr_q + 16'd1;
      if (col_q == width_q - 8'd1) begin
        col_q <= 8'd0;
        row_q <= row_q + 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end else begin
      addr_q <= 16'd0;
      col_q  <= 8'd0;
      row_q  <= 8'd0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      drain_q <= '0;
    end else if (state == S_DRAIN && !Abort) begin
      drain_q <= drain_q + DCW'(1);
    end else begin
      drain_q <= '0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      v1_q     <= 1'b0;
      line1_q  <= 1'b0;
      frame1_q <= 1'b0;
      pix_q    <= 8'd0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else if (Abort) begin
      v1_q     <= 1'b0;
      line1_q  <= 1'b0;
      frame1_q <= 1'b0;
      pix_q    <= 8'd0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      v1_q     <= mem_rd;
      line1_q  <= mem_rd && (col_q == 8'd0);
      frame1_q <= mem_rd && (col_q == 8'd0) && (row_q == 8'd0);
      pix_q    <= v1_q ? bus.MemData : 8'd0;
      line_q   <= v1_q && line1_q;
      frame_q  <= v1_q && frame1_q;
    end
  end

  assign bus.MemRd    = mem_rd;
  assign bus.MemAddr  = addr_q;
  assign bus.PixelOut = pix_q;
  assign bus.FrameOut = frame_q;
  assign bus.LineOut  = line_q;
  assign bus.Width    = width_q;

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// tb/tb_edge_frame_sequencer.sv - self-checking bench for edge_frame_sequencer
module tb_edge_frame_sequencer;
  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       nReset = 1'b1;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [7:0] CfgWidth = 8'd0;
  logic [7:0] CfgHeight = 8'd0;
  logic       Busy;
  logic       Done;

  edge_frame_sequencer_if bus();

  edge_frame_sequencer #(.DRAIN_CYCLES(D)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Start     (Start),
    .Abort     (Abort),
    .CfgWidth  (CfgWidth),
    .CfgHeight (CfgHeight),
    .Busy      (Busy),
    .Done      (Done),
    .bus       (bus.master)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  pix;
    logic        frm;
    logic        ln;
    logic [7:0]  wid;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    int w;
    int h;
    int ca;
    int seed;
    int exp_done;
    int exp_lines;
    int exp_frames;
  } vec_t;

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] data_of(int a, int seed);
    if (seed == 0) return 8'(a);
    return 8'((a * 37) ^ seed ^ (a >> 8));
  endfunction

  // Expected outputs of cycle c of a frame started at the end of cycle 0,
  // with Abort raised during cycle ca (0 = never).
  function automatic obs_t model(int c, int w, int h, int ca, int seed);
    obs_t e;
    int n;
    e = '0;
    e.wid = 8'(w);
    if (ca > 0 && c > ca) return e;
    if (w == 0 || h == 0) begin
      e.done = (c == 1);
      return e;
    end
    n = w * h;
    e.rd   = (c >= 1 && c <= n);
    if (e.rd) e.addr = 16'(c - 1);
    e.busy = (c >= 1 && c <= n + D);
    e.done = (c == n + D + 1);
    if (c >= 3 && c <= n + 2) begin
      e.pix = data_of(c - 3, seed);
      e.frm = (c == 3);
      e.ln  = ((c - 3) % w) == 0;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rd   = bus.MemRd;
    o.addr = bus.MemAddr;
    o.pix  = bus.PixelOut;
    o.frm  = bus.FrameOut;
    o.ln   = bus.LineOut;
    o.wid  = bus.Width;
    o.busy = Busy;
    o.done = Done;
    return o;
  endfunction

  task automatic check_obs(input string name, input int c, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got rd=%b addr=%0d pix=%h frm=%b ln=%b wid=%0d busy=%b done=%b, expected rd=%b addr=%0d pix=%h frm=%b ln=%b wid=%0d busy=%b done=%b",
               name, c, act.rd, act.addr, act.pix, act.frm, act.ln, act.wid, act.busy, act.done,
               exp.rd, exp.addr, exp.pix, exp.frm, exp.ln, exp.wid, exp.busy, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one frame from IDLE, checking every cycle against the model. Entered
  // and left #1 after a rising edge with the block idle.
  task automatic run_frame(input int w, input int h, input int ca, input int seed,
                           input bit noise, output int done_cyc, output int lines,
                           output int frames);
    int n, len, last_busy;
    obs_t a, e, araw;
    logic prd;
    logic [15:0] paddr;
    string name;
    n = w * h;
    if (ca > 0) len = ca + 2;
    else if (n == 0) len = 2;
    else len = n + D + 2;
    if (ca > 0) last_busy = ca - 1;
    else if (n == 0) last_busy = 0;
    else last_busy = n + D;
    name = $sformatf("frame_%0dx%0d_ab%0d", w, h, ca);
    done_cyc = 0;
    lines = 0;
    frames = 0;
    prd = 1'b0;
    paddr = 16'd0;
    CfgWidth = 8'(w);
    CfgHeight = 8'(h);
    Start = 1'b1;
    Abort = 1'b0;
    bus.MemData = 8'($urandom);
    @(posedge Clk); #1;
    for (int c = 1; c <= len; c++) begin
      Start = (noise && c >= 2 && c <= last_busy) ? 1'($urandom % 2) : 1'b0;
      Abort = (c == ca);
      if (noise) begin
        CfgWidth = 8'($urandom);
        CfgHeight = 8'($urandom);
      end
      bus.MemData = prd ? data_of(int'(paddr), seed) : 8'($urandom);
      @(negedge Clk);
      araw = sample();
      a = araw;
      e = model(c, w, h, ca, seed);
      if (!e.rd) a.addr = 16'd0;
      check_obs(name, c, a, e);
      if (araw.done && done_cyc == 0) done_cyc = c;
      lines += int'(araw.ln);
      frames += int'(araw.frm);
      prd = araw.rd;
      paddr = araw.addr;
      @(posedge Clk); #1;
    end
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    obs_t a, e;
    int dc, nl, nf, w, h, n, ca;
    int done_seen;

    vecs[0] = '{4, 3, 0, 0,   17, 3, 1};
    vecs[1] = '{0, 5, 0, 5,    1, 0, 0};
    vecs[2] = '{5, 0, 0, 6,    1, 0, 0};
    vecs[3] = '{4, 3, 6, 0,    0, 1, 1};
    vecs[4] = '{1, 1, 0, 17,   6, 1, 1};
    vecs[5] = '{1, 4, 0, 23,   9, 4, 1};
    vecs[6] = '{7, 1, 0, 41,  12, 1, 1};
    vecs[7] = '{2, 2, 0, 0,    9, 2, 1};
    vecs[8] = '{3, 3, 1, 77,   0, 0, 0};
    vecs[9] = '{2, 2, 6, 99,   0, 2, 1};

    bus.MemData = 8'd0;
    #2 nReset = 1'b0;
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk);
    check_obs("reset_state", 0, sample(), '0);
    @(posedge Clk); #1;
    nReset = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].ca, vecs[i].seed, 1'b0, dc, nl, nf);
      check_int($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      check_int($sformatf("vec%0d_line_pulses", i), nl, vecs[i].exp_lines);
      check_int($sformatf("vec%0d_frame_pulses", i), nf, vecs[i].exp_frames);
    end

    for (int i = 0; i < 20; i++) begin
      w = $urandom_range(0, 10);
      h = $urandom_range(0, 10);
      n = w * h;
      ca = (n > 0 && ($urandom % 4) == 0) ? $urandom_range(1, n + D) : 0;
      run_frame(w, h, ca, $urandom_range(1, 255), 1'b1, dc, nl, nf);
    end

    // Start held high: 2x2 frame restarts on the IDLE cycle after DONE
    CfgWidth = 8'd2;
    CfgHeight = 8'd2;
    Start = 1'b1;
    done_seen = 0;
    @(posedge Clk); #1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clk);
      a = sample();
      if (Done && done_seen == 0) done_seen = c;
      if (c == 10) begin
        e = '0;
        e.wid = 8'd2;
        a.pix = 8'd0;
        check_obs("held_start_idle_gap", c, a, e);
      end
      if (c == 11) begin
        check_int("held_start_restart_rd", int'(a.rd), 1);
        check_int("held_start_restart_addr", int'(a.addr), 0);
      end
      @(posedge Clk); #1;
    end
    check_int("held_start_done_cycle", done_seen, 2 * 2 + D + 1);
    Start = 1'b0;
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    @(negedge Clk);
    e = '0;
    e.wid = 8'd2;
    check_obs("abort_cleanup", 0, sample(), e);
    @(posedge Clk); #1;

    // Abort and Start together in IDLE: Abort wins, geometry not relatched
    CfgWidth = 8'd9;
    CfgHeight = 8'd9;
    Start = 1'b1;
    Abort = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    Abort = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge Clk);
      check_obs("abort_beats_start", c, sample(), e);
      @(posedge Clk); #1;
    end

    // Reset in the middle of a 4x4 fetch
    CfgWidth = 8'd4;
    CfgHeight = 8'd4;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge Clk); #1;
    end
    nReset = 1'b0;
    #1;
    check_obs("reset_mid_fetch", 10, sample(), '0);
    @(posedge Clk); #1;
    nReset = 1'b1;
    for (int c = 11; c <= 13; c++) begin
      @(negedge Clk);
      check_obs("idle_after_reset", c, sample(), '0);
      @(posedge Clk); #1;
    end

    // Largest frame: 16-bit address reaches 65024 without wrapping
    run_frame(255, 255, 0, 91, 1'b1, dc, nl, nf);
    check_int("max_frame_done_cycle", dc, 65025 + D + 1);
    check_int("max_frame_line_pulses", nl, 255);
    check_int("max_frame_frame_pulses", nf, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
